// File: rtl/cadr_pkg.sv
// Shared CADR definitions: M-memory geometry, M-memory FSM states and
// the odd-parity helper used by the optional MMEM_PARITY_EN build.
package cadr_pkg;

    localparam int MMEM_AW = 5;
    localparam int MMEM_DW = 32;

    typedef enum logic {
        MM_INIT,
        MM_RUN
    } mm_state_e;

    // Returns the bit that makes the total count of ones odd; zero-extension
    // does not change the result, so any word up to 64 bits may be passed.
    function automatic logic odd_par(input logic [63:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/mmem_ram.sv
// M-memory storage array: synchronous write, combinational read,
// one read and one write port.
module mmem_ram
    import cadr_pkg::*;
#(
    parameter int AW = MMEM_AW,
    parameter int DW = MMEM_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset; clearing it costs a full sweep, which the
    // owner's INIT sequence performs, so a reset here would only add wiring.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mmem_store.sv
// CADR M-memory: post-reset clear sequencer, registered read with
// write-through bypass, and m-bus gating. Optional parity: MMEM_PARITY_EN.
module mmem_store
    import cadr_pkg::*;
#(
    parameter int DEPTH_LOG2 = MMEM_AW,
    parameter int WIDTH      = MMEM_DW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  state_decode,
    input  logic                  state_write,
    input  logic [DEPTH_LOG2-1:0] madr,
    input  logic                  mrp,
    input  logic                  mwp,
    input  logic                  mpassm,
    input  logic [WIDTH-1:0]      l,
    output logic [WIDTH-1:0]      m,
    output logic [WIDTH-1:0]      mmem_q,
`ifdef MMEM_PARITY_EN
    output logic                  m_parerr,
`endif
    output logic                  init_busy
);

    localparam int DEPTH = 2**DEPTH_LOG2;
`ifdef MMEM_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif
    localparam logic [DEPTH_LOG2:0] CLR_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);

    mm_state_e             state, state_nx;
    logic [DEPTH_LOG2:0]   clr_cnt, clr_nx;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [PW-1:0]         ram_wdata;
    logic [PW-1:0]         ram_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MM_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_nx;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        clr_nx    = clr_cnt;
        ram_we    = mwp;
        ram_waddr = madr;
`ifdef MMEM_PARITY_EN
        ram_wdata = {odd_par(64'(l)), l};
`else
        ram_wdata = l;
`endif
        if (state == MM_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt[DEPTH_LOG2-1:0];
`ifdef MMEM_PARITY_EN
            ram_wdata = {1'b1, {WIDTH{1'b0}}};
`else
            ram_wdata = '0;
`endif
            clr_nx = clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
                state_nx = MM_RUN;
            end
        end
    end

    mmem_ram #(
        .AW (DEPTH_LOG2),
        .DW (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (madr),
        .rdata (ram_rdata)
    );

    // A single madr means a simultaneous read and write always share an address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmem_q <= '0;
        end else if (state == MM_RUN && mrp) begin
            mmem_q <= mwp ? l : ram_rdata[WIDTH-1:0];
        end
    end

`ifdef MMEM_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_parerr <= 1'b0;
        end else if (state == MM_RUN && mrp) begin
            m_parerr <= !mwp && (odd_par(64'(ram_rdata[WIDTH-1:0])) != ram_rdata[WIDTH]);
        end
    end
`endif

    assign init_busy = (state == MM_INIT);
    assign m         = mpassm ? mmem_q : '0;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!reset_n) mrp |-> state_decode);
    assert property (@(posedge clk) disable iff (!reset_n) mwp |-> state_write);
`endif

endmodule

// File: doc/mmem_store.md
Name: mmem_store

Overview:
- 32-word x 32-bit M-memory array for the CADR datapath, directly downstream of M-control.
- Consumes the M-control outputs madr, mrp, mwp and mpassm.
- Returns the registered M-source word to the ALU/shifter input mux.
- Includes a post-reset clear sequencer, so M-memory contents are defined before the first microinstruction issues.

Parameters:
- DEPTH_LOG2, 5, address width; array depth is 2**DEPTH_LOG2.
- WIDTH, 32, data word width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- state_decode  in  1  decode-state strobe from sequencer.
- state_write  in  1  write-state strobe from sequencer.
- madr  in  DEPTH_LOG2  M address from M-control: source address in decode, wadr in write.
- mrp  in  1  M read pulse.
- mwp  in  1  M write pulse.
- mpassm  in  1  M-source select (ir[31]=0); gates output onto the m bus.
- l  in  WIDTH  write data (L register).
- m  out  WIDTH  M-source data to datapath.
- mmem_q  out  WIDTH  raw registered read data, for the debug/spy path.
- init_busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM goes to INIT and clr_cnt goes to 0.
  - mmem_q goes to 0; init_busy goes to 1.
  - Array contents are not reset; the INIT sequence clears them.
- FSM INIT:
  - Each cycle writes 0 to address clr_cnt, then clr_cnt increments.
  - At clr_cnt = DEPTH-1 the write completes and the FSM goes to RUN next edge.
  - INIT lasts exactly DEPTH cycles after reset release.
  - init_busy=1 throughout INIT.
  - mrp and mwp are ignored; mmem_q holds 0.
- FSM RUN:
  - init_busy=0.
  - RUN is left only by reset.
- Write: in RUN, when mwp=1 at a clock edge, array[madr] <= l.
- Read: in RUN, when mrp=1 at a clock edge, mmem_q <= array[madr]. Latency is 1 cycle; mmem_q holds until the next mrp.
- Same-cycle read/write, same address (mrp=1, mwp=1, madr identical): mmem_q <= l, i.e. write-through bypass; the array is also written.
- Same-cycle read/write, different addresses: not possible with a single madr. The same-address rule therefore covers the only simultaneous case.
- Output gating: m = mpassm ? mmem_q : 0 (combinational).
- state_decode and state_write are used only for the assertion below; mrp and mwp are authoritative.
- Assertion (simulation only): mrp must imply state_decode, and mwp must imply state_write.
- Reset mid-INIT restarts the clear at address 0.
- Reset mid-RUN reverts to INIT; all contents are cleared again.
- No wrap hazard: clr_cnt is DEPTH_LOG2+1 bits wide, and INIT terminates on the compare, never on overflow.

Optional Feature:
- Macro: MMEM_PARITY_EN.
- When defined:
  - Each array entry stores one extra odd-parity bit, computed from l on write; INIT writes parity=1 for zero data.
  - On read, parity is checked against the stored bit.
  - Added output port m_parerr (1 bit): registered, set on the read edge when odd parity fails, cleared by the next clean read or by reset.
  - A bypassed read never flags an error.
- When undefined: no parity storage and no m_parerr port; behaviour is otherwise identical.

Decomposition:
- Shared package cadr_pkg holds:
  - MMEM_AW=5 and MMEM_DW=32.
  - The FSM state enum {MM_INIT, MM_RUN}.
  - The odd-parity function.
- One natural sub-module, mmem_ram: a 1-read/1-write synchronous-write, combinational-read array, with optional parity bit width. Instantiated once.
- The FSM, bypass logic, read register and gating stay in mmem_store.

Test Plan:
- Release reset, sample at the listed cycles:
  - init_busy=1 for exactly 32 cycles, then 0.
  - Then mrp at madr=0..31: every mmem_q=0x00000000.
- Write then read, different cycles:
  - mwp, madr=5, l=0xDEADBEEF; next cycle mrp, madr=5 → mmem_q=0xDEADBEEF one cycle later.
  - mpassm=0 → m=0; mpassm=1 → m=0xDEADBEEF.
- Bypass: mrp=1, mwp=1, madr=9, l=0x12345678 same cycle:
  - mmem_q=0x12345678 next cycle.
  - A later read of 9 also returns 0x12345678.
- Reset mid-INIT:
  - Pulse reset_n low at INIT cycle 10 → init_busy stays 1 for 32 further cycles after release.
  - Address 31 previously written 0xFFFFFFFF reads 0 afterwards.
- Ignored-during-INIT: mwp at madr=3, l=0xAAAAAAAA during INIT → after INIT, read of 3 returns 0.
- MMEM_PARITY_EN:
  - Write 0x00000001 to madr=7.
  - Force-flip the stored parity bit via a hierarchical reference.
  - Read 7 → m_parerr=1.
  - Read clean address 8 → m_parerr=0.
